pq_sort_client: RTL and testbench
=================================

# pq_sort_client

Initiator-side controller for the priority-queue device interface: it drives enq/deq into any PQ implementation (heap, shift-register, etc.) to sort a burst of key-value pairs. It accepts a valid/ready input stream, enqueues each item until a `last`-tagged item arrives, then dequeues everything and emits it as a min-key-first output stream through a one-entry output register. It sits between a stream producer and a PQ instance, and doubles as the standard traffic source for PQ benches.

## Interface
Parameters: none. Sizes come from `pq_pkg` (`PQ_CAPACITY`, `kv_t`).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input item present.
- in_ready  out  1  input item accepted when high with in_valid.
- in_kv  in  kv_t  input key-value pair.
- in_last  in  1  marks the final item of a burst.
- out_valid  out  1  output register holds an item.
- out_ready  in  1  consumer accepts the output item.
- out_kv  out  kv_t  sorted item, smallest key first.
- out_last  out  1  marks the final sorted item.
- done  out  1  one-cycle pulse after the final item is consumed.
- order_err  out  1  sticky ordering violation; present only with the check feature (see Configuration).
- pq_enq  out  1  to PQ enq.
- pq_deq  out  1  to PQ deq.
- pq_kvi  out  kv_t  to PQ kvi.
- pq_kvo  in  kv_t  PQ head item; valid when !pq_empty && !pq_busy.
- pq_full, pq_empty, pq_busy  in  1 each  PQ status.

## Operation
- FSM states: FILL, DRAIN. Reset state is FILL.
- Burst counter `cnt` is `$clog2(PQ_CAPACITY+1)` bits. It increments on pq_enq and decrements on pq_deq. It never wraps; the bench asserts this.
- FILL:
  - in_ready = !pq_full && !pq_busy && !rst.
  - On acceptance: pq_enq=1 and pq_kvi=in_kv in the same cycle, combinational pass-through.
  - Accepted item with in_last=1: go to DRAIN.
- DRAIN:
  - in_ready=0.
  - pq_deq = !pq_busy && !pq_empty && cnt!=0 && (!out_valid || out_ready).
  - On pq_deq, the output register loads pq_kvo, sets out_valid, and sets the out_last flag when cnt==1.
  - When out_valid && out_ready && out_last: clear out_valid, pulse done next cycle, return to FILL.
- pq_enq and pq_deq are never asserted together, so replace is never issued.
- out_kv and out_last hold stable while out_valid && !out_ready.
- Equal keys are legal. Tie order is whatever the PQ produces.
- Reset values: out_valid=0, out_last=0, done=0, pq_enq=0, pq_deq=0, in_ready=0, order_err=0, cnt=0, state FILL.
- Reset mid-burst discards all state. The PQ shares rst, so it is emptied as well.

## Timing
- Enqueue: zero-cycle, with pq_enq in the acceptance cycle.
- in_last accepted at cycle t: DRAIN from t+1. First pq_deq at t+1 at the earliest (held off while pq_busy). out_valid at t+2.
- Throughput: 1 item/cycle in both phases when pq_busy=0 and out_ready=1.
- PQ full in FILL: in_ready low until the burst ends. A burst therefore holds at most PQ_CAPACITY items.
- done asserts the cycle after the final out handshake, for exactly 1 cycle.

## Configuration
- `PQ_SORT_CHK_EN` defined:
  - Keeps the last emitted key.
  - Any out handshake whose key is smaller than the previous key of the same burst sets order_err.
  - order_err is sticky until rst.
  - The first item of each burst is never compared.
- `PQ_SORT_CHK_EN` undefined: order_err is tied to 0 and no comparison logic is built.

## Structure
- `pq_pkg` holds `kv_t` (key, value fields), `KEY0`, `VAL0`, `PQ_CAPACITY`, and a shared `pqs_state_t` enum for FILL/DRAIN.
- Single module, no sub-modules. The output register and checker are inline.

## Test plan
- Reset: hold rst 2 cycles -> all outputs 0, in_ready 0 during rst, 1 after with an empty PQ.
- Keys 5,3,9,1 (last on 1), out_ready=1 -> out keys 1,3,5,9; out_last only on 9; done pulse 1 cycle after.
- Same burst with out_ready low 3 cycles mid-drain -> out_kv stable; no pq_deq while the register is stalled; order preserved.
- PQ_CAPACITY items, last on the final one -> in_ready never drops early; all PQ_CAPACITY items emitted sorted; cnt returns to 0.
- Single item key 7 with in_last -> out_valid 2 cycles later with key 7, out_last=1, done pulse; back in FILL.
- `PQ_SORT_CHK_EN` with a faulty PQ model returning 4 then 2 -> order_err rises on the 2 handshake and stays high until rst.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and sizing for the priority-queue device interface and its clients.
package pq_pkg;

    localparam int unsigned KEY_W       = 8;
    localparam int unsigned VAL_W       = 8;
    localparam int unsigned PQ_CAPACITY = 8;
    localparam int unsigned CNT_W       = $clog2(PQ_CAPACITY + 1);

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [VAL_W-1:0] value;
    } kv_t;

    localparam logic [KEY_W-1:0] KEY0 = '0;
    localparam logic [VAL_W-1:0] VAL0 = '0;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } pqs_state_t;

endpackage

// File: rtl/pq_sort_client.sv
// Sorts one burst through an attached PQ: enqueue until in_last, then drain min-first.
// Optional output ordering checker enabled by defining PQ_SORT_CHK_EN.
module pq_sort_client
    import pq_pkg::*;
(
    input  logic clk,
    input  logic rst,

    input  logic in_valid,
    output logic in_ready,
    input  kv_t  in_kv,
    input  logic in_last,

    output logic out_valid,
    input  logic out_ready,
    output kv_t  out_kv,
    output logic out_last,
    output logic done,
    output logic order_err,

    output logic pq_enq,
    output logic pq_deq,
    output kv_t  pq_kvi,
    input  kv_t  pq_kvo,
    input  logic pq_full,
    input  logic pq_empty,
    input  logic pq_busy
);

    pqs_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             out_fire;

    always_comb begin
        in_ready = (state == FILL) && !pq_full && !pq_busy && !rst;
        accept   = in_valid && in_ready;
        pq_enq   = accept;
        pq_kvi   = in_kv;
        out_fire = out_valid && out_ready;
        // The register frees up in the same cycle it is consumed, so drain stays at 1/cycle.
        pq_deq   = (state == DRAIN) && !pq_busy && !pq_empty && (cnt != '0) &&
                   (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_kv    <= '{key: KEY0, value: VAL0};
            done      <= 1'b0;
        end else begin
            done <= out_fire && out_last;

            if (pq_enq) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pq_deq) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (pq_deq) begin
                out_kv    <= pq_kvo;
                out_valid <= 1'b1;
                out_last  <= (cnt == CNT_W'(1));
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end

            case (state)
                FILL:    if (accept && in_last) state <= DRAIN;
                DRAIN:   if (out_fire && out_last) state <= FILL;
                default: state <= FILL;
            endcase
        end
    end

`ifdef PQ_SORT_CHK_EN
    logic [KEY_W-1:0] prev_key;
    logic             have_prev;
    logic             order_err_q;

    // have_prev clears on the final item so each burst starts uncompared.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_key    <= KEY0;
            have_prev   <= 1'b0;
            order_err_q <= 1'b0;
        end else if (out_fire) begin
            prev_key  <= out_kv.key;
            have_prev <= !out_last;
            if (have_prev && (out_kv.key < prev_key)) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_pq_sort_client.sv
// Directed bench for pq_sort_client with a behavioural PQ (min-first, or FIFO to fake a bad PQ).
// Build with PQ_SORT_CHK_EN defined to exercise the ordering checker.
module tb_pq_sort_client;
    import pq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    kv_t  in_kv = '0;
    logic in_last = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    kv_t  out_kv;
    logic out_last;
    logic done;
    logic order_err;
    logic pq_enq;
    logic pq_deq;
    kv_t  pq_kvi;
    kv_t  pq_kvo;
    logic pq_full;
    logic pq_empty;
    logic pq_busy = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pq_sort_client dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kv     (in_kv),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kv    (out_kv),
        .out_last  (out_last),
        .done      (done),
        .order_err (order_err),
        .pq_enq    (pq_enq),
        .pq_deq    (pq_deq),
        .pq_kvi    (pq_kvi),
        .pq_kvo    (pq_kvo),
        .pq_full   (pq_full),
        .pq_empty  (pq_empty),
        .pq_busy   (pq_busy)
    );

    // Behavioural PQ; fifo_mode makes it return insertion order.
    kv_t mem [PQ_CAPACITY];
    int  pcount = 0;
    int  head_idx;
    logic fifo_mode = 1'b0;

    always_comb begin
        head_idx = 0;
        if (!fifo_mode) begin
            for (int i = 1; i < PQ_CAPACITY; i++) begin
                if (i < pcount && mem[i].key < mem[head_idx].key) head_idx = i;
            end
        end
    end

    assign pq_kvo   = mem[head_idx];
    assign pq_empty = (pcount == 0);
    assign pq_full  = (pcount == PQ_CAPACITY);

    always @(posedge clk) begin
        if (rst) begin
            pcount <= 0;
        end else if (pq_enq && pcount < PQ_CAPACITY) begin
            mem[pcount] <= pq_kvi;
            pcount      <= pcount + 1;
        end else if (pq_deq && pcount != 0) begin
            for (int i = 0; i < PQ_CAPACITY - 1; i++) begin
                if (i >= head_idx) mem[i] <= mem[i + 1];
            end
            pcount <= pcount - 1;
        end
    end

    // Cycle counter and output monitor.
    int   cyc = 0;
    logic [KEY_W-1:0] got_key [$];
    logic [VAL_W-1:0] got_val [$];
    logic             got_last [$];
    int   done_cnt = 0;
    int   last_hs_cyc = -10;
    logic stall_prev = 1'b0;
    kv_t  held_kv;
    logic held_last;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                got_key.push_back(out_kv.key);
                got_val.push_back(out_kv.value);
                got_last.push_back(out_last);
                if (out_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (cyc !== last_hs_cyc + 1) begin
                    errors++;
                    $display("FAIL done_timing: done at cycle %0d, required %0d", cyc,
                             last_hs_cyc + 1);
                end
            end
            if (stall_prev) begin
                checks++;
                if (!out_valid || out_kv !== held_kv || out_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b kv=%h last=%b, required v=1 kv=%h last=%b",
                             out_valid, out_kv, out_last, held_kv, held_last);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (pq_deq !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_deq: pq_deq=%b while stalled, required 0", pq_deq);
                end
            end
            checks++;
            if ((pq_enq && pq_deq) || dut.cnt > CNT_W'(PQ_CAPACITY)) begin
                errors++;
                $display("FAIL invariant: enq=%b deq=%b cnt=%0d, required no overlap, cnt<=%0d",
                         pq_enq, pq_deq, dut.cnt, PQ_CAPACITY);
            end
            stall_prev = out_valid && !out_ready;
            held_kv    = out_kv;
            held_last  = out_last;
        end
    end

    task automatic clear_obs();
        got_key.delete();
        got_val.delete();
        got_last.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic [KEY_W-1:0] k, input logic last, output int waits);
        waits    = 0;
        in_valid = 1'b1;
        in_kv    = '{key: k, value: k ^ 8'hA5};
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            errors++;
            $display("FAIL send_timeout: in_ready=0 for key %0d, required 1", k);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while (done_cnt == 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done: done high %0d cycles, required 1", name, done_cnt);
        end
    endtask

    task automatic check_out(input string name, input logic [KEY_W-1:0] exp [$]);
        checks++;
        if (got_key.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d items, required %0d", name, got_key.size(),
                     exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (got_key[i] !== exp[i] || got_val[i] !== (exp[i] ^ 8'hA5) ||
                    got_last[i] !== (i == exp.size() - 1)) begin
                    errors++;
                    $display("FAIL %s_item%0d: got key=%0d val=%h last=%b, required %0d %h %b",
                             name, i, got_key[i], got_val[i], got_last[i], exp[i],
                             exp[i] ^ 8'hA5, i == exp.size() - 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, done, pq_enq, pq_deq, order_err} !== 7'b0 ||
            dut.cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b cnt=%0d, required 0000000 cnt=0",
                     {in_ready, out_valid, out_last, done, pq_enq, pq_deq, order_err}, dut.cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || dut.state !== FILL) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b state=%0d, required 1 FILL", in_ready,
                     dut.state);
        end
        pq_busy = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: in_ready=%b with pq_busy, required 0", in_ready);
        end
        pq_busy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [KEY_W-1:0] exp [$] = '{8'd1, 8'd3, 8'd5, 8'd9};
        int w;
        clear_obs();
        out_ready = 1'b1;
        send(8'd5, 1'b0, w);
        send(8'd3, 1'b0, w);
        send(8'd9, 1'b0, w);
        send(8'd1, 1'b1, w);
        wait_done("basic");
        check_out("basic", exp);
    endtask

    task automatic test_stall();
        logic [KEY_W-1:0] exp [$] = '{8'd1, 8'd3, 8'd5, 8'd9};
        int w;
        int t = 0;
        clear_obs();
        out_ready = 1'b1;
        send(8'd5, 1'b0, w);
        send(8'd3, 1'b0, w);
        send(8'd9, 1'b0, w);
        send(8'd1, 1'b1, w);
        while (got_key.size() < 1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (got_key.size() !== 1 || out_valid !== 1'b1 || out_kv.key !== 8'd3) begin
            errors++;
            $display("FAIL stall_state: got n=%0d v=%b key=%0d, required n=1 v=1 key=3",
                     got_key.size(), out_valid, out_kv.key);
        end
        out_ready = 1'b1;
        wait_done("stall");
        check_out("stall", exp);
    endtask

    task automatic test_capacity();
        logic [KEY_W-1:0] in_keys [$] = '{8'd200, 8'd17, 8'd17, 8'd90, 8'd3, 8'd255, 8'd0,
                                          8'd42};
        logic [KEY_W-1:0] exp [$] = '{8'd0, 8'd3, 8'd17, 8'd17, 8'd42, 8'd90, 8'd200, 8'd255};
        int w;
        int total = 0;
        clear_obs();
        out_ready = 1'b1;
        for (int i = 0; i < PQ_CAPACITY; i++) begin
            send(in_keys[i], i == PQ_CAPACITY - 1, w);
            total += w;
        end
        checks++;
        if (total !== 0) begin
            errors++;
            $display("FAIL cap_ready: in_ready low for %0d cycles during fill, required 0",
                     total);
        end
        wait_done("cap");
        check_out("cap", exp);
        checks++;
        if (dut.cnt !== '0 || dut.state !== FILL) begin
            errors++;
            $display("FAIL cap_cnt: cnt=%0d state=%0d, required 0 FILL", dut.cnt, dut.state);
        end
    endtask

    task automatic test_single();
        int w;
        clear_obs();
        out_ready = 1'b1;
        send(8'd7, 1'b1, w);
        @(negedge clk);
        checks++;
        if (pq_deq !== 1'b1 || out_valid !== 1'b0 || dut.state !== DRAIN) begin
            errors++;
            $display("FAIL single_t1: deq=%b v=%b state=%0d, required 1 0 DRAIN", pq_deq,
                     out_valid, dut.state);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_kv.key !== 8'd7 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL single_t2: v=%b key=%0d last=%b, required 1 7 1", out_valid,
                     out_kv.key, out_last);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || dut.state !== FILL) begin
            errors++;
            $display("FAIL single_t3: done=%b v=%b state=%0d, required 1 0 FILL", done,
                     out_valid, dut.state);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_t4: done=%b, required 0", done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_order_chk();
        logic exp_err;
        int w;
        int t = 0;
`ifdef PQ_SORT_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        clear_obs();
        out_ready = 1'b1;
        fifo_mode = 1'b1;
        send(8'd4, 1'b0, w);
        send(8'd2, 1'b1, w);
        while (got_key.size() < 1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (order_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_first: order_err=%b after first item, required 0", order_err);
        end
        wait_done("chk");
        checks++;
        if (order_err !== exp_err) begin
            errors++;
            $display("FAIL chk_rise: order_err=%b, required %b", order_err, exp_err);
        end
        fifo_mode = 1'b0;
        clear_obs();
        send(8'd6, 1'b0, w);
        send(8'd5, 1'b1, w);
        wait_done("chk2");
        checks++;
        if (order_err !== exp_err) begin
            errors++;
            $display("FAIL chk_sticky: order_err=%b, required %b", order_err, exp_err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (order_err !== 1'b0) begin
            errors++;
            $display("FAIL chk_reset: order_err=%b after rst, required 0", order_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_capacity();
        test_single();
        test_order_chk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
